// File: rtl/i2s_top_tx.sv
// i2s_top_tx: I2S (Philips) master transmitter; generates sclk_o/wsel_o and sends words MSB-first on sdat_o.
// Latency: a held word goes out from the fall tick that opens its channel's slot (MSB seen on the next sclk rise).
// Backpressure: one-word holding register; ready_o is low while it is occupied and valid_i is ignored then.
//
// Ports:
//   clk_i, rst_ni          system clock, asynchronous active-low reset
//   data_i/valid_i/ready_o producer handshake; lr_chnl_o tags the channel of the next accepted word
//   underrun_o             one-clk pulse when a slot opens without a word for its channel
//   sclk_o/wsel_o/sdat_o   I2S bus; sdat_o changes on the sclk_o falling edge
// Build option: define I2S_TX_UNDERRUN_REPEAT_EN to resend the channel's previous word on underrun
// (otherwise an underrun slot carries zeros).

module i2s_top_tx #(
    parameter int WORD_WIDTH = 16,
    parameter int CLK_DIV    = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [WORD_WIDTH-1:0] data_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic                  lr_chnl_o,
    output logic                  underrun_o,
    output logic                  sclk_o,
    output logic                  wsel_o,
    output logic                  sdat_o
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CNT_W = $clog2(WORD_WIDTH);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(WORD_WIDTH - 1);

    logic [DIV_W-1:0]      div_cnt;
    logic [CNT_W-1:0]      bit_cnt;
    logic [WORD_WIDTH-1:0] shift_q;
    logic [WORD_WIDTH-1:0] hold_dat;
    logic [WORD_WIDTH-1:0] fill_word;
    logic [WORD_WIDTH-1:0] slot_word;
    logic                  hold_vld;
    logic                  hold_tag;
    logic                  div_wrap;
    logic                  fall_tick;
    logic                  slot_start;
    logic                  accept;
    logic                  load_ok;

    assign div_wrap   = (div_cnt == DIV_LAST);
    assign fall_tick  = div_wrap && sclk_o;
    assign slot_start = fall_tick && (bit_cnt == '0);
    assign ready_o    = ~hold_vld;
    assign accept     = valid_i && ready_o;
    // Only a word tagged for the slot's own channel may be loaded; anything
    // else waits in the holding register for the matching slot.
    assign load_ok    = slot_start && hold_vld && (hold_tag == wsel_o);
    assign slot_word  = load_ok ? hold_dat : fill_word;

    // Bit clock generation
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_cnt <= '0;
            sclk_o  <= 1'b0;
        end else if (div_wrap) begin
            div_cnt <= '0;
            sclk_o  <= ~sclk_o;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // Holding register; accept and load can never coincide because accept
    // requires the register to be empty.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hold_vld  <= 1'b0;
            hold_tag  <= 1'b0;
            hold_dat  <= '0;
            lr_chnl_o <= 1'b0;
        end else if (load_ok) begin
            hold_vld <= 1'b0;
        end else if (accept) begin
            hold_vld  <= 1'b1;
            hold_dat  <= data_i;
            hold_tag  <= lr_chnl_o;
            lr_chnl_o <= ~lr_chnl_o;
        end
    end

`ifdef I2S_TX_UNDERRUN_REPEAT_EN
    logic [WORD_WIDTH-1:0] last_l;
    logic [WORD_WIDTH-1:0] last_r;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_l <= '0;
            last_r <= '0;
        end else if (load_ok) begin
            if (hold_tag) begin
                last_r <= hold_dat;
            end else begin
                last_l <= hold_dat;
            end
        end
    end

    assign fill_word = wsel_o ? last_r : last_l;
`else
    assign fill_word = '0;
`endif

    // Serialiser: bit_cnt 0 opens a slot (MSB), 1..WORD_WIDTH-2 shift out the
    // middle bits, WORD_WIDTH-1 sends the LSB while wsel_o already flips to the
    // next channel (one-bit WS delay).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bit_cnt    <= BIT_LAST;
            shift_q    <= '0;
            sdat_o     <= 1'b0;
            wsel_o     <= 1'b1;
            underrun_o <= 1'b0;
        end else begin
            underrun_o <= 1'b0;
            if (fall_tick) begin
                if (bit_cnt == BIT_LAST) begin
                    // After WORD_WIDTH-2 shifts the word's LSB sits just below the top bit.
                    sdat_o  <= shift_q[WORD_WIDTH-2];
                    wsel_o  <= ~wsel_o;
                    bit_cnt <= '0;
                end else if (bit_cnt == '0) begin
                    shift_q    <= slot_word;
                    sdat_o     <= slot_word[WORD_WIDTH-1];
                    underrun_o <= ~load_ok;
                    bit_cnt    <= CNT_W'(1);
                end else begin
                    sdat_o  <= shift_q[WORD_WIDTH-2];
                    shift_q <= shift_q << 1;
                    bit_cnt <= bit_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_top_tx.sv
// tb_i2s_top_tx: self-checking bench for i2s_top_tx (CLK_DIV=1 instance plus a CLK_DIV=4 instance).
// A bus decoder rebuilds {channel, word} from sclk rises; tasks queue expected words and compare.
// Prints one summary line at the end.

module tb_i2s_top_tx;
    localparam int W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n0 = 1'b0;
    logic         rst_n4 = 1'b0;
    logic [W-1:0] data0 = '0;
    logic [W-1:0] data4 = '0;
    logic         valid0 = 1'b0;
    logic         valid4 = 1'b0;
    logic         ready0, lr0, ur0, sclk0, ws0, sd0;
    logic         ready4, lr4, ur4, sclk4, ws4, sd4;

    i2s_top_tx #(.WORD_WIDTH(W), .CLK_DIV(1)) u_dut (
        .clk_i(clk), .rst_ni(rst_n0), .data_i(data0), .valid_i(valid0), .ready_o(ready0),
        .lr_chnl_o(lr0), .underrun_o(ur0), .sclk_o(sclk0), .wsel_o(ws0), .sdat_o(sd0)
    );

    i2s_top_tx #(.WORD_WIDTH(W), .CLK_DIV(4)) u_dut4 (
        .clk_i(clk), .rst_ni(rst_n4), .data_i(data4), .valid_i(valid4), .ready_o(ready4),
        .lr_chnl_o(lr4), .underrun_o(ur4), .sclk_o(sclk4), .wsel_o(ws4), .sdat_o(sd4)
    );

    int total = 0;
    int bad   = 0;

    logic [W:0]   exp0[$];
    logic [W:0]   exp4[$];
    logic [W:0]   rx0[$];
    logic [W:0]   rx4[$];
    logic [W-1:0] last_w [2];

    // Bus decoder: a bit sampled on an sclk rise belongs to the channel wsel
    // showed on the previous rise; a wsel change marks that word's LSB.
    logic [1:0]   ws_prev   = 2'b11;
    logic [1:0]   sclk_prev = 2'b00;
    logic [W-1:0] acc [2];
    int           cnt [2];
    int           uc [2];
    int           last_rise [2];
    int           prev_rise [2];
    int           cyc = 0;

    always @(negedge clk) begin : monitor
        logic [1:0] sv, wv, dv, uv, rv;
        cyc++;
        sv = {sclk4, sclk0};
        wv = {ws4, ws0};
        dv = {sd4, sd0};
        uv = {ur4, ur0};
        rv = {rst_n4, rst_n0};
        for (int i = 0; i < 2; i++) begin
            if (!rv[i]) begin
                ws_prev[i]   = 1'b1;
                sclk_prev[i] = 1'b0;
                cnt[i]       = 0;
                acc[i]       = '0;
            end else begin
                if (uv[i]) uc[i]++;
                if (sv[i] && !sclk_prev[i]) begin
                    prev_rise[i] = last_rise[i];
                    last_rise[i] = cyc;
                    acc[i] = {acc[i][W-2:0], dv[i]};
                    cnt[i]++;
                    if (wv[i] != ws_prev[i]) begin
                        if (cnt[i] == W) begin
                            if (i == 0) rx0.push_back({ws_prev[i], acc[i]});
                            else        rx4.push_back({ws_prev[i], acc[i]});
                        end
                        cnt[i] = 0;
                    end
                    ws_prev[i] = wv[i];
                end
                sclk_prev[i] = sv[i];
            end
        end
    end

    // Expected content of an underrun slot for a channel.
    function automatic logic [W-1:0] fill(input int ch);
        logic [W-1:0] f;
        f = last_w[ch];
`ifndef I2S_TX_UNDERRUN_REPEAT_EN
        f = '0;
`endif
        return f;
    endfunction

    task automatic push_word(input bit ch, input logic [W-1:0] w);
        last_w[ch] = w;
        exp0.push_back({ch, w});
    endtask

    task automatic push_ur(input bit ch);
        exp0.push_back({ch, fill(int'(ch))});
    endtask

    // Offer one word; call right after a posedge. Returns once it was accepted or the budget expired.
    task automatic offer(input bit which, input logic [W-1:0] w, output bit ok);
        if (which) begin data4 = w; valid4 = 1'b1; end
        else       begin data0 = w; valid0 = 1'b1; end
        ok = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (which ? ready4 : ready0) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        if (which) valid4 = 1'b0;
        else       valid0 = 1'b0;
    endtask

    task automatic wait_rx(input bit which, input int n, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if ((which ? rx4.size() : rx0.size()) >= n) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
        end
    endtask

    task automatic test_reset();
        logic [5:0] got;
        last_w[0] = '0;
        last_w[1] = '0;
        rst_n0 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        got = {sclk0, ws0, sd0, ready0, lr0, ur0};
        total++;
        if (got !== 6'b010100) begin
            bad++;
            $display("FAIL reset_values got=%b want=010100 (sclk,wsel,sdat,ready,lr,ur)", got);
        end
        @(negedge clk);
        rst_n0 = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if ({sclk0, ws0} !== 2'b11) begin
            bad++;
            $display("FAIL first_rise got sclk,wsel=%b%b want=11", sclk0, ws0);
        end
        @(posedge clk);
        #1;
        total++;
        if ({sclk0, ws0} !== 2'b00) begin
            bad++;
            $display("FAIL first_fall_tick got sclk,wsel=%b%b want=00", sclk0, ws0);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int base;
        logic [W:0] got, want;
        base = uc[0];
        push_word(1'b0, 16'hA5A5);
        offer(1'b0, 16'hA5A5, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL b2b_accept_a5a5 got=timeout want=accepted"); end
        push_word(1'b1, 16'h3C3C);
        offer(1'b0, 16'h3C3C, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL b2b_accept_3c3c got=timeout want=accepted"); end
        wait_rx(1'b0, 2, ok);
        if (!ok) begin
            total++; bad++;
            $display("FAIL b2b_rx got=%0d words want=2", rx0.size());
        end
        for (int k = 0; k < 2 && rx0.size() > 0 && exp0.size() > 0; k++) begin
            got = rx0.pop_front();
            want = exp0.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL b2b_word%0d got=%h want=%h", k, got, want);
            end
        end
        total++;
        if (uc[0] - base !== 0) begin
            bad++;
            $display("FAIL b2b_underruns got=%0d want=0", uc[0] - base);
        end
    endtask

    task automatic test_underrun();
        bit ok;
        int base;
        logic [W:0] got, want;
        base = uc[0];
        push_ur(1'b0);
        push_ur(1'b1);
        wait_rx(1'b0, 2, ok);
        if (!ok) begin
            total++; bad++;
            $display("FAIL underrun_rx got=%0d words want=2", rx0.size());
        end
        for (int k = 0; k < 2 && rx0.size() > 0 && exp0.size() > 0; k++) begin
            got = rx0.pop_front();
            want = exp0.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL underrun_word%0d got=%h want=%h", k, got, want);
            end
        end
        total++;
        if (uc[0] - base !== 2) begin
            bad++;
            $display("FAIL underrun_pulses got=%0d want=2", uc[0] - base);
        end
    endtask

    task automatic test_late_left();
        bit ok;
        int base;
        logic [W:0] got, want;
        base = uc[0];
        // Current left slot has just opened with nothing held.
        push_ur(1'b0);
        push_ur(1'b1);
        push_word(1'b0, 16'h1234);
        push_ur(1'b1);
        repeat (4) @(posedge clk);
        #1;
        offer(1'b0, 16'h1234, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL late_accept got=timeout want=accepted"); end
        total++;
        if (lr0 !== 1'b1) begin bad++; $display("FAIL late_lr_chnl got=%b want=1", lr0); end
        total++;
        if (ready0 !== 1'b0) begin bad++; $display("FAIL late_ready got=%b want=0", ready0); end
        wait_rx(1'b0, 4, ok);
        if (!ok) begin
            total++; bad++;
            $display("FAIL late_rx got=%0d words want=4", rx0.size());
        end
        for (int k = 0; k < 4 && rx0.size() > 0 && exp0.size() > 0; k++) begin
            got = rx0.pop_front();
            want = exp0.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL late_word%0d got=%h want=%h", k, got, want);
            end
        end
        total++;
        if (uc[0] - base !== 3) begin
            bad++;
            $display("FAIL late_underruns got=%0d want=3", uc[0] - base);
        end
    endtask

    task automatic test_mid_reset();
        bit ok;
        int base;
        logic [5:0] got6;
        logic [W:0] got, want;
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk);
            #1;
            if (ws0) begin ok = 1'b1; break; end
        end
        total++;
        if (!ok) begin bad++; $display("FAIL midrst_wait_right got=timeout want=wsel high"); end
        repeat (16) @(posedge clk);
        #1;
        rst_n0 = 1'b0;
        #1;
        got6 = {sclk0, ws0, sd0, ready0, lr0, ur0};
        total++;
        if (got6 !== 6'b010100) begin
            bad++;
            $display("FAIL midrst_values got=%b want=010100 (sclk,wsel,sdat,ready,lr,ur)", got6);
        end
        rx0.delete();
        exp0.delete();
        last_w[0] = '0;
        last_w[1] = '0;
        @(negedge clk);
        rst_n0 = 1'b1;
        base = uc[0];
        @(posedge clk);
        #1;
        push_word(1'b0, 16'hBEEF);
        offer(1'b0, 16'hBEEF, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL midrst_accept got=timeout want=accepted"); end
        wait_rx(1'b0, 1, ok);
        if (!ok) begin
            total++; bad++;
            $display("FAIL midrst_rx got=%0d words want=1", rx0.size());
        end
        if (rx0.size() > 0 && exp0.size() > 0) begin
            got = rx0.pop_front();
            want = exp0.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL midrst_word got=%h want=%h", got, want);
            end
        end
        total++;
        if (uc[0] - base !== 0) begin
            bad++;
            $display("FAIL midrst_underruns got=%0d want=0", uc[0] - base);
        end
    endtask

    task automatic test_div4_loopback();
        bit ok;
        int base;
        logic [W-1:0] w;
        logic [W:0] got, want;
        @(negedge clk);
        rst_n4 = 1'b1;
        base = uc[1];
        @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) begin
            w = 16'($urandom());
            exp4.push_back({1'(i % 2), w});
            offer(1'b1, w, ok);
            total++;
            if (!ok) begin bad++; $display("FAIL div4_accept%0d got=timeout want=accepted", i); end
        end
        wait_rx(1'b1, 10, ok);
        if (!ok) begin
            total++; bad++;
            $display("FAIL div4_rx got=%0d words want=10", rx4.size());
        end
        for (int k = 0; k < 10 && rx4.size() > 0 && exp4.size() > 0; k++) begin
            got = rx4.pop_front();
            want = exp4.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL div4_word%0d got=%h want=%h", k, got, want);
            end
        end
        total++;
        if (last_rise[1] - prev_rise[1] !== 8) begin
            bad++;
            $display("FAIL div4_sclk_period got=%0d want=8", last_rise[1] - prev_rise[1]);
        end
        total++;
        if (uc[1] - base !== 0) begin
            bad++;
            $display("FAIL div4_underruns got=%0d want=0", uc[1] - base);
        end
        total++;
        if (lr4 !== 1'b0) begin
            bad++;
            $display("FAIL div4_lr_chnl got=%b want=0", lr4);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_underrun();
        test_late_left();
        test_mid_reset();
        test_div4_loopback();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
